// File: rtl/poker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : poker_pkg
// Brief   : Card geometry, deck size, FSM encoding and LFSR constants shared
//           by the poker dealer blocks.
// Revision: 1.0
// ============================================================================
package poker_pkg;
    localparam int NUM_W       = 4;
    localparam int SUIT_W      = 2;
    localparam int NUM_PLAYERS = 9;
    localparam int HOLE_CARDS  = 18;
    localparam int PUB_CARDS   = 3;
    localparam int TOTAL_CARDS = HOLE_CARDS + PUB_CARDS;
    localparam int RATE_W      = 7;
    localparam int DECK_SIZE   = 52;
    localparam int IDX_W       = 6;
    localparam int LFSR_W      = 16;
    localparam int LAT_W       = 11;

    // Taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;
endpackage
`default_nettype wire

// File: rtl/poker_deck_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : poker_deck_lfsr
// Brief   : 16-bit Fibonacci LFSR with zero-safe seed load; decodes the low six
//           bits into a candidate card {num, suit} plus an in-deck flag.
// Revision: 1.0
// ============================================================================
module poker_deck_lfsr
    import poker_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              shift_en,
    input  logic [LFSR_W-1:0] seed,
    output logic [IDX_W-1:0]  cand_idx,
    output logic [NUM_W-1:0]  cand_num,
    output logic [SUIT_W-1:0] cand_suit,
    output logic              cand_in_range
);
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_en) begin
            // An all-zero state would lock the register, so substitute the default
            lfsr_d = (seed == '0) ? SEED_DEFAULT : seed;
        end else if (shift_en) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign cand_idx = lfsr_q[IDX_W-1:0];

    always_comb begin
        cand_in_range = (cand_idx < 6'(DECK_SIZE));
        cand_suit     = 2'd0;
        cand_num      = 4'd0;
        if (cand_idx < 6'd13) begin
            cand_suit = 2'd0;
            cand_num  = 4'(cand_idx + 6'd2);
        end else if (cand_idx < 6'd26) begin
            cand_suit = 2'd1;
            cand_num  = 4'(cand_idx - 6'd11);
        end else if (cand_idx < 6'd39) begin
            cand_suit = 2'd2;
            cand_num  = 4'(cand_idx - 6'd24);
        end else if (cand_idx < 6'd52) begin
            cand_suit = 2'd3;
            cand_num  = 4'(cand_idx - 6'd37);
        end
    end
endmodule
`default_nettype wire

// File: rtl/poker_dealer.sv
`default_nettype none
// ============================================================================
// Module  : poker_dealer
// Brief   : Deals 21 distinct cards to the win-rate calculator, waits for its
//           answer and captures the win rates and response latency.
// Revision: 1.0
// ============================================================================
module poker_dealer
    import poker_pkg::*;
#(
    parameter int          TIMEOUT      = 1000,
    parameter logic [15:0] SEED_DEFAULT = LFSR_SEED_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            load_seed,
    input  logic [LFSR_W-1:0]               seed,
    output logic                            in_valid,
    output logic [HOLE_CARDS*NUM_W-1:0]     in_hole_num,
    output logic [HOLE_CARDS*SUIT_W-1:0]    in_hole_suit,
    output logic [PUB_CARDS*NUM_W-1:0]      in_pub_num,
    output logic [PUB_CARDS*SUIT_W-1:0]     in_pub_suit,
    input  logic                            out_valid,
    input  logic [NUM_PLAYERS*RATE_W-1:0]   out_win_rate,
    output logic                            busy,
    output logic                            done,
    output logic [NUM_PLAYERS*RATE_W-1:0]   result,
    output logic [LAT_W-1:0]                latency,
    output logic                            timeout,
    output logic                            proto_err
);
    localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(TIMEOUT + 1);
    localparam logic [4:0]       LAST_SLOT = 5'(TOTAL_CARDS - 1);

    logic [1:0]                        state_q, state_d;
    logic [4:0]                        draw_cnt_q, draw_cnt_d;
    logic [LAT_W-1:0]                  lat_cnt_q, lat_cnt_d;
    logic [DECK_SIZE-1:0]              used_q, used_d;
    logic [NUM_W-1:0]                  slot_num_q [TOTAL_CARDS];
    logic [NUM_W-1:0]                  slot_num_d [TOTAL_CARDS];
    logic [SUIT_W-1:0]                 slot_suit_q [TOTAL_CARDS];
    logic [SUIT_W-1:0]                 slot_suit_d [TOTAL_CARDS];
    logic [NUM_PLAYERS*RATE_W-1:0]     result_q, result_d;
    logic [LAT_W-1:0]                  latency_q, latency_d;
    logic                              timeout_q, timeout_d;
    logic                              proto_err_q, proto_err_d;
    logic                              done_q, done_d;

    logic                              load_en;
    logic                              shift_en;
    logic [IDX_W-1:0]                  cand_idx;
    logic [NUM_W-1:0]                  cand_num;
    logic [SUIT_W-1:0]                 cand_suit;
    logic                              cand_in_range;
    logic                              accept;

    poker_deck_lfsr #(
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_deck (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .shift_en      (shift_en),
        .seed          (seed),
        .cand_idx      (cand_idx),
        .cand_num      (cand_num),
        .cand_suit     (cand_suit),
        .cand_in_range (cand_in_range)
    );

    assign in_valid = (state_q == ST_SEND);
    assign busy     = (state_q != ST_IDLE);
    assign accept   = cand_in_range && !used_q[cand_idx];

    always_comb begin
        state_d     = state_q;
        draw_cnt_d  = draw_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        used_d      = used_q;
        slot_num_d  = slot_num_q;
        slot_suit_d = slot_suit_q;
        result_d    = result_q;
        latency_d   = latency_q;
        timeout_d   = timeout_q;
        done_d      = 1'b0;
        load_en     = 1'b0;
        shift_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_en = load_seed;
                if (start) begin
                    used_d     = '0;
                    draw_cnt_d = '0;
                    timeout_d  = 1'b0;
                    state_d    = ST_DRAW;
                end
            end
            ST_DRAW: begin
                shift_en = 1'b1;
                if (accept) begin
                    used_d[cand_idx]        = 1'b1;
                    slot_num_d[draw_cnt_q]  = cand_num;
                    slot_suit_d[draw_cnt_q] = cand_suit;
                    draw_cnt_d              = draw_cnt_q + 5'd1;
                    if (draw_cnt_q == LAST_SLOT) begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                lat_cnt_d = LAT_W'(1);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A response arriving on the last allowed cycle still wins over the timeout
                if (out_valid) begin
                    result_d  = out_win_rate;
                    latency_d = lat_cnt_q;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else if (lat_cnt_q == LAT_LIMIT) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        proto_err_d = proto_err_q;
        if ((out_valid && in_valid) ||
            (out_valid && state_q != ST_WAIT) ||
            (!out_valid && state_q == ST_WAIT && out_win_rate != '0)) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            draw_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            used_q      <= '0;
            result_q    <= '0;
            latency_q   <= '0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < TOTAL_CARDS; i++) begin
                slot_num_q[i]  <= '0;
                slot_suit_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            draw_cnt_q  <= draw_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            used_q      <= used_d;
            result_q    <= result_d;
            latency_q   <= latency_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
            done_q      <= done_d;
            slot_num_q  <= slot_num_d;
            slot_suit_q <= slot_suit_d;
        end
    end

    // Card buses are gated so nothing stale is visible outside the strobe cycle
    always_comb begin
        in_hole_num  = '0;
        in_hole_suit = '0;
        in_pub_num   = '0;
        in_pub_suit  = '0;
        if (in_valid) begin
            for (int i = 0; i < HOLE_CARDS; i++) begin
                in_hole_num[i*NUM_W +: NUM_W]    = slot_num_q[i];
                in_hole_suit[i*SUIT_W +: SUIT_W] = slot_suit_q[i];
            end
            for (int j = 0; j < PUB_CARDS; j++) begin
                in_pub_num[j*NUM_W +: NUM_W]    = slot_num_q[HOLE_CARDS+j];
                in_pub_suit[j*SUIT_W +: SUIT_W] = slot_suit_q[HOLE_CARDS+j];
            end
        end
    end

    assign done      = done_q;
    assign result    = result_q;
    assign latency   = latency_q;
    assign timeout   = timeout_q;
    assign proto_err = proto_err_q;
endmodule
`default_nettype wire
